median_select_ctrl: RTL and testbench
=====================================

// Module: median_select_ctrl
// PURPOSE
// - Sequencing controller for the iterative pivot/partition median search of the median filter.
// - Captures one window of BUFF_SIZE 8-bit samples, then runs repeated full scans.
// - Each scan counts lower/equal/larger vs the pivot and tracks min/max per side; a decide cycle
//   then either ends the search or narrows the value window and computes the next pivot and rank.
// - Emits the rank-MEDIAN_POS sample (zero-based, ascending) on a valid/ready stream.
// PARAMETERS
// - BUFF_SIZE     32                    samples per window (power of 2, >=4)
// - MEDIAN_POS    BUFF_SIZE/2           zero-based rank selected (< BUFF_SIZE)
// - BUFF_SIZE_BIT $clog2(BUFF_SIZE)+1   width of sizes, counts and ranks
// - MAX_PASSES    10                    pass limit before the error exit
// PORTS
// - clock       in   1              rising-edge clock
// - reset_n     in   1              async reset, active low
// - in_pix      in   8              input sample
// - in_valid    in   1              in_pix valid
// - in_ready    out  1              sample accepted when in_valid & in_ready
// - out_median  out  8              selected sample
// - out_err     out  1              pass limit hit; out_median = last pivot
// - out_valid   out  1              result valid; held until out_ready
// - out_ready   in   1              downstream accepts the result
// - busy        out  1              high in SCAN, DECIDE and OUT
// - pass_cnt    out  4              scans completed in the current search
// BEHAVIOUR
// - Reset (async assert, sync release): state=LOAD, all counters 0, window lo=0/hi=255.
//   Reset values: in_ready=1, out_valid=0, out_err=0, out_median=0, busy=0, pass_cnt=0.
//   A reset mid-operation discards the window.
// - LOAD: in_ready=1. Each accepted sample is written to mem[wr_idx] and wr_idx increments;
//   gaps in in_valid are allowed.
//   - Running min/max are tracked while loading.
//   - On the BUFF_SIZE-th accept: pivot=(min+max)>>1 (9-bit sum), pos=MEDIAN_POS, lo=0, hi=255,
//     then go to SCAN. in_ready=0 from the next cycle.
// - SCAN: exactly BUFF_SIZE cycles, one mem entry per cycle; only samples with lo<=s<=hi count.
//   - s<pivot: lower_size++ and update min_lower/max_lower.
//   - s==pivot: equal_size++.
//   - s>pivot: larger_size++ and update min_larger/max_larger.
//   - Accumulators clear on SCAN entry. Min trackers start at 255 and max trackers at 0.
// - DECIDE (1 cycle): pass_cnt++, then apply the first matching rule.
//   - lower_size<=pos<lower_size+equal_size: found. out_median=pivot, go to OUT.
//   - lower_size>pos: hi=pivot-1, pivot=(min_lower+max_lower)>>1, pos unchanged, go to SCAN.
//   - otherwise: lo=pivot+1, pos=pos-(lower_size+equal_size),
//     pivot=(min_larger+max_larger)>>1, go to SCAN.
//   - If pass_cnt reaches MAX_PASSES without a match: out_err=1, out_median=pivot, go to OUT.
//   - Sums are computed at BUFF_SIZE_BIT+1 bits; no wrap is allowed.
// - The window strictly shrinks each pass, so 8-bit data terminates in at most 9 passes.
//   The error exit is a safety net only.
// - OUT: out_valid=1; out_median and out_err are stable while out_valid=1 and out_ready=0.
//   - On out_valid & out_ready, next cycle: out_valid=0, out_err=0, pass_cnt=0, wr_idx=0,
//     state=LOAD, in_ready=1.
//   - No sample is accepted in the handshake cycle.
// - Latency from the last load accept to out_valid: passes*(BUFF_SIZE+1)+1 cycles.
// - The window is not double-buffered; throughput is one window per search.
// TESTING
// (BUFF_SIZE=8, MEDIAN_POS=4 unless noted)
// - Load 0,1,..,7 -> pivots 3,5,4; out_median=4, pass_cnt=3, out_err=0,
//   out_valid rises 3*9+1=28 cycles after the last accept.
// - Load eight samples of 200 -> one pass, equal_size=8; out_median=200, pass_cnt=1.
// - Load 255,0,255,0,255,0,255,0 -> pass 1 pivot 127 (lower=4), pass 2 pivot 255;
//   out_median=255, pass_cnt=2.
// - Random in_valid gaps during LOAD plus out_ready low for 5 cycles -> no sample lost;
//   in_ready=0 while busy; out_median/out_valid held steady; a second window is loaded
//   and processed after the handshake.
// - Assert reset_n low mid-SCAN of window 2 -> outputs take reset values immediately;
//   a fresh window 7,6,5,4,3,2,1,0 yields out_median=4.
// - Random windows with BUFF_SIZE=32 and ranks 0, 16, 31 vs a sort model -> exact match,
//   pass_cnt<=9, out_err never set.

Source files
------------

// File: rtl/median_select_ctrl.sv
// Sequencing controller for an iterative pivot/partition median search over one captured window.
// Each pass scans the window once, then a decide cycle either reports the result or narrows [lo,hi].
module median_select_ctrl #(
  parameter int BUFF_SIZE     = 32,
  parameter int MEDIAN_POS    = BUFF_SIZE / 2,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int MAX_PASSES    = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] in_pix,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_median,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [3:0] pass_cnt
);

  localparam int IDX_W = $clog2(BUFF_SIZE);
  localparam int SUM_W = BUFF_SIZE_BIT + 1;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SCAN   = 2'd1,
    S_DECIDE = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  function automatic logic [7:0] mid8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8:1];
  endfunction

  state_t                   state_q, state_d;
  logic [7:0]               mem_q [BUFF_SIZE];
  logic                     mem_we_s;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d, scan_idx_q, scan_idx_d;
  logic [7:0]               ld_min_q, ld_min_d, ld_max_q, ld_max_d;
  logic [7:0]               new_min_s, new_max_s;
  logic [7:0]               pivot_q, pivot_d, lo_q, lo_d, hi_q, hi_d;
  logic [BUFF_SIZE_BIT-1:0] pos_q, pos_d;
  logic [BUFF_SIZE_BIT-1:0] lower_q, lower_d, equal_q, equal_d, larger_q, larger_d;
  logic [7:0]               min_lo_q, min_lo_d, max_lo_q, max_lo_d;
  logic [7:0]               min_hi_q, min_hi_d, max_hi_q, max_hi_d;
  logic [7:0]               out_median_q, out_median_d;
  logic                     out_err_q, out_err_d, out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d, busy_q, busy_d;
  logic [3:0]               pass_cnt_q, pass_cnt_d, pass_inc_s;
  logic                     clear_acc_s;
  logic [7:0]               s_s;
  logic [SUM_W-1:0]         lower_ext_s, pos_ext_s, le_sum_s;
  logic                     found_s;

  assign s_s         = mem_q[scan_idx_q];
  assign lower_ext_s = SUM_W'(lower_q);
  assign pos_ext_s   = SUM_W'(pos_q);
  assign le_sum_s    = SUM_W'(lower_q) + SUM_W'(equal_q);
  assign found_s     = (lower_ext_s <= pos_ext_s) && (pos_ext_s < le_sum_s);
  assign pass_inc_s  = pass_cnt_q + 4'd1;
  assign new_min_s   = (in_pix < ld_min_q) ? in_pix : ld_min_q;
  assign new_max_s   = (in_pix > ld_max_q) ? in_pix : ld_max_q;

  // Next-state, datapath and output computation
  always_comb begin
    state_d      = state_q;
    mem_we_s     = 1'b0;
    wr_idx_d     = wr_idx_q;
    scan_idx_d   = scan_idx_q;
    ld_min_d     = ld_min_q;
    ld_max_d     = ld_max_q;
    pivot_d      = pivot_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    pos_d        = pos_q;
    lower_d      = lower_q;
    equal_d      = equal_q;
    larger_d     = larger_q;
    min_lo_d     = min_lo_q;
    max_lo_d     = max_lo_q;
    min_hi_d     = min_hi_q;
    max_hi_d     = max_hi_q;
    out_median_d = out_median_q;
    out_err_d    = out_err_q;
    out_valid_d  = 1'b0;
    pass_cnt_d   = pass_cnt_q;
    clear_acc_s  = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          mem_we_s = 1'b1;
          wr_idx_d = wr_idx_q + IDX_W'(1);
          ld_min_d = new_min_s;
          ld_max_d = new_max_s;
          if (wr_idx_q == IDX_W'(BUFF_SIZE - 1)) begin
            pivot_d     = mid8(new_min_s, new_max_s);
            pos_d       = BUFF_SIZE_BIT'(MEDIAN_POS);
            lo_d        = 8'd0;
            hi_d        = 8'd255;
            ld_min_d    = 8'd255;
            ld_max_d    = 8'd0;
            clear_acc_s = 1'b1;
            state_d     = S_SCAN;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end
      S_SCAN: begin
        scan_idx_d = scan_idx_q + IDX_W'(1);
        if ((s_s >= lo_q) && (s_s <= hi_q)) begin
          if (s_s < pivot_q) begin
            lower_d  = lower_q + BUFF_SIZE_BIT'(1);
            min_lo_d = (s_s < min_lo_q) ? s_s : min_lo_q;
            max_lo_d = (s_s > max_lo_q) ? s_s : max_lo_q;
          end else if (s_s == pivot_q) begin
            equal_d = equal_q + BUFF_SIZE_BIT'(1);
          end else begin
            larger_d = larger_q + BUFF_SIZE_BIT'(1);
            min_hi_d = (s_s < min_hi_q) ? s_s : min_hi_q;
            max_hi_d = (s_s > max_hi_q) ? s_s : max_hi_q;
          end
        end else begin
          lower_d = lower_q;
        end
        if (scan_idx_q == IDX_W'(BUFF_SIZE - 1)) begin
          state_d = S_DECIDE;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_DECIDE: begin
        pass_cnt_d = pass_inc_s;
        if (found_s) begin
          out_median_d = pivot_q;
          state_d      = S_OUT;
        end else if (pass_inc_s == 4'(MAX_PASSES)) begin
          out_err_d    = 1'b1;
          out_median_d = pivot_q;
          state_d      = S_OUT;
        end else if (lower_ext_s > pos_ext_s) begin
          hi_d        = pivot_q - 8'd1;
          pivot_d     = mid8(min_lo_q, max_lo_q);
          clear_acc_s = 1'b1;
          state_d     = S_SCAN;
        end else begin
          // Everything at or below the pivot is discarded, so the rank shifts down
          lo_d        = pivot_q + 8'd1;
          pos_d       = BUFF_SIZE_BIT'(pos_ext_s - le_sum_s);
          pivot_d     = mid8(min_hi_q, max_hi_q);
          clear_acc_s = 1'b1;
          state_d     = S_SCAN;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          pass_cnt_d  = 4'd0;
          wr_idx_d    = '0;
          state_d     = S_LOAD;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    if (clear_acc_s) begin
      lower_d    = '0;
      equal_d    = '0;
      larger_d   = '0;
      min_lo_d   = 8'd255;
      max_lo_d   = 8'd0;
      min_hi_d   = 8'd255;
      max_hi_d   = 8'd0;
      scan_idx_d = '0;
    end else begin
      clear_acc_s = 1'b0;
    end

    in_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_LOAD);
  end

  // Window storage; contents are meaningless after reset until reloaded
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[wr_idx_q] <= in_pix;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_LOAD;
      wr_idx_q     <= '0;
      scan_idx_q   <= '0;
      ld_min_q     <= 8'd255;
      ld_max_q     <= 8'd0;
      pivot_q      <= 8'd0;
      lo_q         <= 8'd0;
      hi_q         <= 8'd255;
      pos_q        <= '0;
      lower_q      <= '0;
      equal_q      <= '0;
      larger_q     <= '0;
      min_lo_q     <= 8'd255;
      max_lo_q     <= 8'd0;
      min_hi_q     <= 8'd255;
      max_hi_q     <= 8'd0;
      out_median_q <= 8'd0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      pass_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      scan_idx_q   <= scan_idx_d;
      ld_min_q     <= ld_min_d;
      ld_max_q     <= ld_max_d;
      pivot_q      <= pivot_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      pos_q        <= pos_d;
      lower_q      <= lower_d;
      equal_q      <= equal_d;
      larger_q     <= larger_d;
      min_lo_q     <= min_lo_d;
      max_lo_q     <= max_lo_d;
      min_hi_q     <= min_hi_d;
      max_hi_q     <= max_hi_d;
      out_median_q <= out_median_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      pass_cnt_q   <= pass_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_median = out_median_q;
  assign out_err    = out_err_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign pass_cnt   = pass_cnt_q;

endmodule

// File: tb/tb_median_select_ctrl.sv
// Self-checking bench: directed windows on an 8-sample instance and random windows on
// three 32-sample instances (ranks 0, 16, 31) checked against a sort-based reference.
module tb_median_select_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;

  logic [7:0] in_pix8;
  logic       in_valid8, out_ready8;
  logic       in_ready8, out_err8, out_valid8, busy8;
  logic [7:0] out_median8;
  logic [3:0] pass_cnt8;

  logic [7:0]      in_pix32;
  logic            in_valid32, out_ready32;
  logic [2:0]      in_ready32, out_err32, out_valid32, busy32;
  logic [2:0][7:0] out_median32;
  logic [2:0][3:0] pass_cnt32;

  int total = 0;
  int bad   = 0;
  logic [7:0] w8 [8];
  logic [7:0] w32 [32];

  always #5 clock = ~clock;

  median_select_ctrl #(.BUFF_SIZE(8), .MEDIAN_POS(4)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_pix(in_pix8), .in_valid(in_valid8),
    .in_ready(in_ready8), .out_median(out_median8), .out_err(out_err8),
    .out_valid(out_valid8), .out_ready(out_ready8), .busy(busy8), .pass_cnt(pass_cnt8)
  );

  for (genvar g = 0; g < 3; g++) begin : g32
    localparam int RK = (g == 0) ? 0 : ((g == 1) ? 16 : 31);
    median_select_ctrl #(.BUFF_SIZE(32), .MEDIAN_POS(RK)) dut32 (
      .clock(clock), .reset_n(reset_n), .in_pix(in_pix32), .in_valid(in_valid32),
      .in_ready(in_ready32[g]), .out_median(out_median32[g]), .out_err(out_err32[g]),
      .out_valid(out_valid32[g]), .out_ready(out_ready32), .busy(busy32[g]),
      .pass_cnt(pass_cnt32[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_rank8(input int rk);
    int q[$];
    for (int i = 0; i < 8; i++) q.push_back(int'(w8[i]));
    q.sort();
    return q[rk];
  endfunction

  function automatic int ref_rank32(input int rk);
    int q[$];
    for (int i = 0; i < 32; i++) q.push_back(int'(w32[i]));
    q.sort();
    return q[rk];
  endfunction

  task automatic load8(input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        int ng;
        ng = $urandom_range(0, 3);
        repeat (ng) begin
          @(negedge clock);
          in_valid8 = 1'b0;
          in_pix8   = 8'($urandom);
        end
      end
      @(negedge clock);
      check("ld_ready8", in_ready8, 32'd1);
      in_valid8 = 1'b1;
      in_pix8   = w8[i];
    end
    @(negedge clock);
    in_valid8 = 1'b0;
  endtask

  task automatic load32(input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps) begin
        int ng;
        ng = $urandom_range(0, 2);
        repeat (ng) begin
          @(negedge clock);
          in_valid32 = 1'b0;
        end
      end
      @(negedge clock);
      in_valid32 = 1'b1;
      in_pix32   = w32[i];
    end
    @(negedge clock);
    in_valid32 = 1'b0;
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    while (out_valid8 !== 1'b1 && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic hs8();
    @(negedge clock);
    out_ready8 = 1'b1;
    @(negedge clock);
    out_ready8 = 1'b0;
    check("hs_valid8", out_valid8, 32'd0);
    check("hs_ready8", in_ready8, 32'd1);
    check("hs_pcnt8", pass_cnt8, 32'd0);
    check("hs_err8", out_err8, 32'd0);
  endtask

  initial begin
    int cyc;
    int expm;
    reset_n = 1'b0;
    in_valid8 = 1'b0; in_pix8 = 8'd0; out_ready8 = 1'b0;
    in_valid32 = 1'b0; in_pix32 = 8'd0; out_ready32 = 1'b0;
    #12;
    check("rst_ready", in_ready8, 32'd1);
    check("rst_valid", out_valid8, 32'd0);
    check("rst_busy", busy8, 32'd0);
    check("rst_median", out_median8, 32'd0);
    check("rst_pcnt", pass_cnt8, 32'd0);
    check("rst_ready32", in_ready32, 32'd7);
    @(negedge clock);
    reset_n = 1'b1;

    // Ascending ramp: three passes, fixed latency
    for (int i = 0; i < 8; i++) w8[i] = 8'(i);
    load8(1'b0);
    check("ramp_ready_low", in_ready8, 32'd0);
    wait8(cyc);
    check("ramp_latency", cyc, 32'd28);
    check("ramp_median", out_median8, 32'd4);
    check("ramp_pcnt", pass_cnt8, 32'd3);
    check("ramp_err", out_err8, 32'd0);
    hs8();

    for (int i = 0; i < 8; i++) w8[i] = 8'd200;
    load8(1'b0);
    wait8(cyc);
    check("flat_median", out_median8, 32'd200);
    check("flat_pcnt", pass_cnt8, 32'd1);
    hs8();

    for (int i = 0; i < 8; i++) w8[i] = (i % 2 == 0) ? 8'd255 : 8'd0;
    load8(1'b0);
    wait8(cyc);
    check("alt_median", out_median8, 32'd255);
    check("alt_pcnt", pass_cnt8, 32'd2);
    hs8();

    // Random window with gaps, stalled result, then a junk beat during the handshake
    for (int i = 0; i < 8; i++) w8[i] = 8'($urandom);
    expm = ref_rank8(4);
    load8(1'b1);
    check("gap_busy", busy8, 32'd1);
    check("gap_ready_low", in_ready8, 32'd0);
    wait8(cyc);
    repeat (5) begin
      @(negedge clock);
      check("stall_valid", out_valid8, 32'd1);
      check("stall_median", out_median8, 32'(expm));
      check("stall_ready", in_ready8, 32'd0);
    end
    @(negedge clock);
    out_ready8 = 1'b1;
    in_valid8  = 1'b1;
    in_pix8    = 8'd255;
    @(negedge clock);
    out_ready8 = 1'b0;
    in_valid8  = 1'b0;
    check("hs2_valid", out_valid8, 32'd0);
    check("hs2_ready", in_ready8, 32'd1);
    for (int i = 0; i < 8; i++) w8[i] = 8'(80 - 10 * i);
    load8(1'b1);
    wait8(cyc);
    check("win2_median", out_median8, 32'd50);
    hs8();

    // Reset in the middle of a scan
    for (int i = 0; i < 8; i++) w8[i] = 8'($urandom);
    load8(1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", in_ready8, 32'd1);
    check("mid_rst_busy", busy8, 32'd0);
    check("mid_rst_valid", out_valid8, 32'd0);
    check("mid_rst_median", out_median8, 32'd0);
    check("mid_rst_pcnt", pass_cnt8, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) w8[i] = 8'(7 - i);
    load8(1'b0);
    wait8(cyc);
    check("desc_median", out_median8, 32'd4);
    check("desc_err", out_err8, 32'd0);
    hs8();

    // Random 32-sample windows, three ranks in parallel
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) begin
        if (t % 3 == 0) w32[i] = 8'($urandom_range(100, 104));
        else if (t % 3 == 1) w32[i] = 8'($urandom);
        else w32[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(250, 255));
      end
      load32(t % 2 == 1);
      cyc = 0;
      while (out_valid32 !== 3'b111 && cyc < 2000) begin
        @(negedge clock);
        cyc++;
      end
      for (int g = 0; g < 3; g++) begin
        int rk;
        rk = (g == 0) ? 0 : ((g == 1) ? 16 : 31);
        check("r32_median", out_median32[g], 32'(ref_rank32(rk)));
        check("r32_pcnt_le9", 32'(pass_cnt32[g] <= 4'd9), 32'd1);
        check("r32_err", out_err32[g], 32'd0);
      end
      @(negedge clock);
      out_ready32 = 1'b1;
      @(negedge clock);
      out_ready32 = 1'b0;
      check("r32_hs_valid", out_valid32, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
